// File: rtl/load_store_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// load_store_unit : RV32 MEM-stage data-memory initiator. Splits misaligned
//                   accesses into two word transactions and extends loads.
// Revision 1.0
// ---------------------------------------------------------------------------
module load_store_unit #(
   parameter int X_LEN = 32
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             lsu_valid_i,
   input  logic             lsu_we_i,
   input  logic [2:0]       lsu_funct3_i,
   input  logic [X_LEN-1:0] lsu_addr_i,
   input  logic [X_LEN-1:0] lsu_wdata_i,
   output logic             lsu_stall_o,
   output logic             lsu_done_o,
   output logic [X_LEN-1:0] lsu_rdata_o,
   output logic             lsu_err_o,
   output logic             mem_req_o,
   output logic             mem_we_o,
   output logic [X_LEN-1:0] mem_addr_o,
   output logic [3:0]       mem_be_o,
   output logic [X_LEN-1:0] mem_wdata_o,
   input  logic             mem_gnt_i,
   input  logic             mem_rvalid_i,
   input  logic [X_LEN-1:0] mem_rdata_i
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ1  = 3'd1,
      S_WAIT1 = 3'd2,
      S_REQ2  = 3'd3,
      S_WAIT2 = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t           state_q;
   logic             we_q;
   logic [2:0]       funct3_q;
   logic [1:0]       off_q;
   logic             split_q;
   logic [X_LEN-1:0] rdata1_q;
   logic [X_LEN-1:0] addr2_q;
   logic [3:0]       be2_q;
   logic [X_LEN-1:0] wdata2_q;

   // Request decode straight from the operands, used in the capture cycle.
   logic [2:0]         size_d;
   logic [3:0]         mask_d;
   logic [7:0]         be_wide_d;
   logic [2*X_LEN-1:0] wdata_wide_d;
   logic               split_d;
   logic               illegal_d;
   logic [X_LEN-1:0]   addr_base_d;

   always_comb begin
      size_d = 3'd1;
      mask_d = 4'b0001;
      case (lsu_funct3_i[1:0])
         2'b01:   begin size_d = 3'd2; mask_d = 4'b0011; end
         2'b10:   begin size_d = 3'd4; mask_d = 4'b1111; end
         default: ;
      endcase
      be_wide_d    = {4'b0000, mask_d} << lsu_addr_i[1:0];
      wdata_wide_d = {{X_LEN{1'b0}}, lsu_wdata_i} << {lsu_addr_i[1:0], 3'b000};
      split_d      = ({1'b0, lsu_addr_i[1:0]} + size_d) > 3'd4;
      illegal_d    = (lsu_funct3_i == 3'b011) || (lsu_funct3_i[2:1] == 2'b11) ||
                     (lsu_we_i && lsu_funct3_i[2]);
      addr_base_d  = {lsu_addr_i[X_LEN-1:2], 2'b00};
   end

   // Second word (zero when not split) lands above the first before the shift.
   logic [2*X_LEN-1:0] merged_d;
   logic [2*X_LEN-1:0] shifted_d;
   logic [X_LEN-1:0]   v_d;
   logic [X_LEN-1:0]   ext_d;

   always_comb begin
      if (state_q == S_WAIT2) merged_d = {mem_rdata_i, rdata1_q};
      else                    merged_d = {{X_LEN{1'b0}}, mem_rdata_i};
      shifted_d = merged_d >> {off_q, 3'b000};
      v_d       = shifted_d[X_LEN-1:0];
      case (funct3_q)
         3'b000:  ext_d = {{(X_LEN-8){v_d[7]}},   v_d[7:0]};
         3'b001:  ext_d = {{(X_LEN-16){v_d[15]}}, v_d[15:0]};
         3'b100:  ext_d = {{(X_LEN-8){1'b0}},     v_d[7:0]};
         3'b101:  ext_d = {{(X_LEN-16){1'b0}},    v_d[15:0]};
         default: ext_d = v_d;
      endcase
      if (we_q) ext_d = '0;
   end

   assign lsu_stall_o = rst_n_i &&
                        (((state_q == S_IDLE) && lsu_valid_i) ||
                         ((state_q != S_IDLE) && (state_q != S_DONE)));

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= S_IDLE;
         we_q        <= 1'b0;
         funct3_q    <= 3'b000;
         off_q       <= 2'b00;
         split_q     <= 1'b0;
         rdata1_q    <= '0;
         addr2_q     <= '0;
         be2_q       <= 4'b0000;
         wdata2_q    <= '0;
         lsu_done_o  <= 1'b0;
         lsu_rdata_o <= '0;
         lsu_err_o   <= 1'b0;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_be_o    <= 4'b0000;
         mem_wdata_o <= '0;
      end else begin
         lsu_done_o  <= 1'b0;
         lsu_err_o   <= 1'b0;
         lsu_rdata_o <= '0;
         case (state_q)
            S_IDLE: begin
               if (lsu_valid_i) begin
                  we_q     <= lsu_we_i;
                  funct3_q <= lsu_funct3_i;
                  off_q    <= lsu_addr_i[1:0];
                  split_q  <= split_d;
                  addr2_q  <= addr_base_d + X_LEN'(4);
                  be2_q    <= be_wide_d[7:4];
                  wdata2_q <= wdata_wide_d[2*X_LEN-1:X_LEN];
                  if (illegal_d) begin
                     state_q    <= S_DONE;
                     lsu_done_o <= 1'b1;
                     lsu_err_o  <= 1'b1;
                  end else begin
                     state_q     <= S_REQ1;
                     mem_req_o   <= 1'b1;
                     mem_we_o    <= lsu_we_i;
                     mem_addr_o  <= addr_base_d;
                     mem_be_o    <= be_wide_d[3:0];
                     mem_wdata_o <= wdata_wide_d[X_LEN-1:0];
                  end
               end
            end
            S_REQ1, S_REQ2: begin
               if (mem_gnt_i) begin
                  state_q     <= (state_q == S_REQ1) ? S_WAIT1 : S_WAIT2;
                  mem_req_o   <= 1'b0;
                  mem_we_o    <= 1'b0;
                  mem_addr_o  <= '0;
                  mem_be_o    <= 4'b0000;
                  mem_wdata_o <= '0;
               end
            end
            S_WAIT1: begin
               if (mem_rvalid_i) begin
                  rdata1_q <= mem_rdata_i;
                  if (split_q) begin
                     state_q     <= S_REQ2;
                     mem_req_o   <= 1'b1;
                     mem_we_o    <= we_q;
                     mem_addr_o  <= addr2_q;
                     mem_be_o    <= be2_q;
                     mem_wdata_o <= wdata2_q;
                  end else begin
                     state_q     <= S_DONE;
                     lsu_done_o  <= 1'b1;
                     lsu_rdata_o <= ext_d;
                  end
               end
            end
            S_WAIT2: begin
               if (mem_rvalid_i) begin
                  state_q     <= S_DONE;
                  lsu_done_o  <= 1'b1;
                  lsu_rdata_o <= ext_d;
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
